// File: rtl/apb_master_rmw_pkg.sv
// Shared types for the APB3 read/write/read-modify-write master.
package apb_master_rmw_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RMW   = 2'b11
  } apb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RSP    = 2'b11
  } apb_state_e;

  function automatic logic xfer_is_write(apb_op_e op, logic wr_phase);
    return (op == OP_WRITE) || ((op == OP_RMW) && wr_phase);
  endfunction

  // A disabled timeout (0 cycles) still needs a 1-bit counter to stay legal.
  function automatic int timer_width(int cyc);
    return (cyc > 0) ? $clog2(cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_master_rmw_if.sv
// Command/response port plus APB3 bus signals of the master, grouped for port connection.
interface apb_master_rmw_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [1:0]        cmd_op_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              psel_o;
  logic              penable_o;
  logic [ADDR_W-1:0] paddr_o;
  logic              pwrite_o;
  logic [DATA_W-1:0] pwdata_o;
  logic              pready_i;
  logic [DATA_W-1:0] prdata_i;
  logic              pslverr_i;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_wdata_i,
    input  pready_i, prdata_i, pslverr_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_wdata_i,
    output pready_i, prdata_i, pslverr_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
  );
endinterface

// File: rtl/apb_master_rmw_wait_timer.sv
// ACCESS-phase wait timer: down-counter loaded on clear, flags the last permitted wait cycle.
module apb_wait_timer
  import apb_master_rmw_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = timer_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - LAST_VAL;
    end
  end

  // count reaches 1 on the TIMEOUT_CYC-th ACCESS cycle; that cycle is the last chance for pready.
  assign expired = (TIMEOUT_CYC != 0) && (count == LAST_VAL);

endmodule

// File: rtl/apb_master_rmw.sv
// APB3 master executing READ, WRITE and RMW-increment commands with one-cycle responses.
//  state     | meaning
//  ST_IDLE   | ready for a command
//  ST_SETUP  | APB setup phase (psel=1, penable=0)
//  ST_ACCESS | APB access phase, waiting for pready or timeout
//  ST_RSP    | one-cycle response pulse
module apb_master_rmw
  import apb_master_rmw_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int INC_VAL     = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            reset,
  apb_master_rmw_if.master bus
);
  localparam logic [DATA_W-1:0] INC_ADD = DATA_W'(INC_VAL);

  apb_state_e        state, state_n;
  apb_op_e           op_q;
  apb_op_e           cmd_op;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              wr_phase_q;
  logic              xfer_write;
  logic              accept;
  logic              acc_done;
  logic              acc_abort;
  logic              rmw_chain;
  logic              tmr_clear;
  logic              tmr_enable;
  logic              tmr_expired;

  assign cmd_op     = apb_op_e'(bus.cmd_op_i);
  assign xfer_write = xfer_is_write(op_q, wr_phase_q);

  apb_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n         = state;
    accept          = 1'b0;
    acc_done        = 1'b0;
    acc_abort       = 1'b0;
    rmw_chain       = 1'b0;
    tmr_clear       = 1'b0;
    tmr_enable      = 1'b0;
    bus.cmd_ready_o = 1'b0;
    bus.rsp_valid_o = 1'b0;
    bus.rsp_rdata_o = '0;
    bus.rsp_err_o   = 1'b0;
    bus.psel_o      = 1'b0;
    bus.penable_o   = 1'b0;
    bus.paddr_o     = '0;
    bus.pwrite_o    = 1'b0;
    bus.pwdata_o    = '0;

    unique case (state)
      ST_IDLE: begin
        // Ready is held low while reset is asserted so every output reads 0 during reset.
        bus.cmd_ready_o = !reset;
        accept          = bus.cmd_valid_i && (cmd_op != OP_NOP);
        if (accept) begin
          state_n = ST_SETUP;
        end
      end
      ST_SETUP: begin
        bus.psel_o   = 1'b1;
        bus.paddr_o  = addr_q;
        bus.pwrite_o = xfer_write;
        bus.pwdata_o = xfer_write ? wdata_q : '0;
        tmr_clear    = 1'b1;
        state_n      = ST_ACCESS;
      end
      ST_ACCESS: begin
        bus.psel_o    = 1'b1;
        bus.penable_o = 1'b1;
        bus.paddr_o   = addr_q;
        bus.pwrite_o  = xfer_write;
        bus.pwdata_o  = xfer_write ? wdata_q : '0;
        tmr_enable    = 1'b1;
        if (bus.pready_i) begin
          acc_done = 1'b1;
          if ((op_q == OP_RMW) && !wr_phase_q && !bus.pslverr_i) begin
            rmw_chain = 1'b1;
            state_n   = ST_SETUP;
          end else begin
            state_n = ST_RSP;
          end
        end else if (tmr_expired) begin
          acc_abort = 1'b1;
          state_n   = ST_RSP;
        end
      end
      ST_RSP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_rdata_o = rdata_q;
        bus.rsp_err_o   = err_q;
        state_n         = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= OP_NOP;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wr_phase_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= cmd_op;
        addr_q     <= bus.cmd_addr_i;
        wdata_q    <= bus.cmd_wdata_i;
        rdata_q    <= '0;
        err_q      <= 1'b0;
        wr_phase_q <= 1'b0;
      end
      if (acc_done) begin
        err_q <= bus.pslverr_i;
        if (!xfer_write) begin
          rdata_q <= bus.prdata_i;
        end
        if (rmw_chain) begin
          wr_phase_q <= 1'b1;
          wdata_q    <= bus.prdata_i + INC_ADD;
        end
      end
      // An aborted access reports no data, even if an RMW read had already completed.
      if (acc_abort) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_rmw.sv
// Bench for apb_master_rmw: vector table, hand-written corner sequences and random commands vs a transaction model.
module tb_apb_master_rmw;
  import apb_master_rmw_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int INC = 1;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  apb_master_rmw_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_rmw #(
    .ADDR_W(AW), .DATA_W(DW), .INC_VAL(INC), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          w0;
    int          w1;
    logic        e0;
    logic        e1;
    logic [31:0] x_rdata;
    logic        x_err;
    int          x_lat;
  } txn_t;

  int checks = 0;
  int errors = 0;

  int          m_n, m_lat;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        m_write [2];
  logic [31:0] m_wdata [2];
  int          m_acc [2];

  int          o_n, o_lat, o_unstable, o_leak;
  int          o_acc [4];
  logic        o_write [4];
  logic [31:0] o_addr [4];
  logic [31:0] o_wdata [4];
  logic        o_got, o_err, o_psel_after, o_ready_after, o_rsp_after;
  logic [31:0] o_rdata;

  txn_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(logic [1:0] op, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rd0, logic [31:0] rd1, int w0, int w1,
                              logic e0, logic e1, logic [31:0] xr, logic xe, int xl);
    txn_t t;
    t.op = op; t.addr = addr; t.wdata = wdata; t.rd0 = rd0; t.rd1 = rd1;
    t.w0 = w0; t.w1 = w1; t.e0 = e0; t.e1 = e1;
    t.x_rdata = xr; t.x_err = xe; t.x_lat = xl;
    return t;
  endfunction

  // Transaction-level expectation: list of APB transfers, their access lengths, and the response.
  task automatic model(input txn_t t);
    logic        wr, to, ek;
    logic [31:0] rdk;
    int          wk;
    m_n = 0; m_err = 1'b0; m_rdata = '0; m_lat = 1;
    for (int k = 0; k < 2; k++) begin
      if (k == 1 && t.op != 2'(OP_RMW)) break;
      wr  = (t.op == 2'(OP_WRITE)) || (k == 1);
      wk  = (k == 0) ? t.w0 : t.w1;
      rdk = (k == 0) ? t.rd0 : t.rd1;
      ek  = (k == 0) ? t.e0 : t.e1;
      m_write[k] = wr;
      m_wdata[k] = (t.op == 2'(OP_WRITE)) ? t.wdata : t.rd0 + 32'(INC);
      m_n++;
      to = (TMO != 0) && (wk >= TMO);
      m_acc[k] = to ? TMO : wk + 1;
      m_lat += 1 + m_acc[k];
      if (to) begin
        m_err = 1'b1;
        m_rdata = '0;
        break;
      end
      m_err = ek;
      if (!wr) m_rdata = rdk;
      if (ek) break;
    end
  endtask

  task automatic run_txn(input txn_t t, input string tag);
    int n;
    o_n = 0; o_unstable = 0; o_leak = 0; o_got = 1'b0; o_lat = 0; o_rdata = '0; o_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      o_acc[k] = 0; o_addr[k] = '0; o_write[k] = 1'b0; o_wdata[k] = '0;
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_op_i = t.op; bus.cmd_addr_i = t.addr; bus.cmd_wdata_i = t.wdata;
    n = 0;
    while (!bus.cmd_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 64'(bus.cmd_ready_o), 64'd1);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0; bus.cmd_op_i = 2'b00; bus.cmd_addr_i = $urandom(); bus.cmd_wdata_i = $urandom();
    n = 1;
    while (!o_got && n < 80) begin
      if (bus.psel_o && !bus.penable_o) begin
        if (o_n < 4) begin
          o_addr[o_n] = bus.paddr_o; o_write[o_n] = bus.pwrite_o; o_wdata[o_n] = bus.pwdata_o;
        end
        o_n++;
      end else if (bus.psel_o && bus.penable_o && o_n > 0 && o_n <= 4) begin
        o_acc[o_n-1]++;
        if (bus.paddr_o !== o_addr[o_n-1] || bus.pwrite_o !== o_write[o_n-1] ||
            bus.pwdata_o !== o_wdata[o_n-1]) o_unstable++;
      end
      if (bus.rsp_valid_o) begin
        o_got = 1'b1; o_lat = n; o_rdata = bus.rsp_rdata_o; o_err = bus.rsp_err_o;
      end else if (bus.rsp_rdata_o !== '0 || bus.rsp_err_o !== 1'b0) begin
        o_leak++;
      end
      // Outside ACCESS the slave lines carry noise the master must ignore.
      bus.pready_i = ($urandom_range(0, 1) != 0);
      bus.prdata_i = $urandom();
      bus.pslverr_i = ($urandom_range(0, 1) != 0);
      if (bus.psel_o && bus.penable_o) begin
        bus.pready_i = 1'b0;
        if (o_n == 1 && o_acc[0] == t.w0 + 1) begin
          bus.pready_i = 1'b1; bus.prdata_i = t.rd0; bus.pslverr_i = t.e0;
        end else if (o_n == 2 && o_acc[1] == t.w1 + 1) begin
          bus.pready_i = 1'b1; bus.prdata_i = t.rd1; bus.pslverr_i = t.e1;
        end else if (o_n > 2) begin
          bus.pready_i = 1'b1;
        end
      end
      @(negedge clk);
      n++;
    end
    o_psel_after = bus.psel_o; o_ready_after = bus.cmd_ready_o; o_rsp_after = bus.rsp_valid_o;
    bus.pready_i = 1'b0; bus.pslverr_i = 1'b0;
  endtask

  task automatic check_txn(input txn_t t, input string tag);
    model(t);
    chk({tag, "_rsp_seen"}, 64'(o_got), 64'd1);
    chk({tag, "_lat"}, 64'(o_lat), 64'(m_lat));
    chk({tag, "_rdata"}, 64'(o_rdata), 64'(m_rdata));
    chk({tag, "_err"}, 64'(o_err), 64'(m_err));
    chk({tag, "_n_xfer"}, 64'(o_n), 64'(m_n));
    for (int k = 0; k < m_n && k < o_n; k++) begin
      chk($sformatf("%s_x%0d_addr", tag, k), 64'(o_addr[k]), 64'(t.addr));
      chk($sformatf("%s_x%0d_pwrite", tag, k), 64'(o_write[k]), 64'(m_write[k]));
      if (m_write[k]) chk($sformatf("%s_x%0d_pwdata", tag, k), 64'(o_wdata[k]), 64'(m_wdata[k]));
      chk($sformatf("%s_x%0d_access_cycles", tag, k), 64'(o_acc[k]), 64'(m_acc[k]));
    end
    chk({tag, "_unstable"}, 64'(o_unstable), 64'd0);
    chk({tag, "_rsp_leak"}, 64'(o_leak), 64'd0);
    chk({tag, "_psel_after"}, 64'(o_psel_after), 64'd0);
    chk({tag, "_rsp_one_cycle"}, 64'(o_rsp_after), 64'd0);
    chk({tag, "_ready_after"}, 64'(o_ready_after), 64'd1);
  endtask

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return $urandom_range(0, 3);
    if (r < 16) return TMO - 1;
    if (r < 18) return TMO;
    return 255;
  endfunction

  initial begin
    txn_t t;
    int   n, seen;

    bus.cmd_valid_i = 1'b0; bus.cmd_op_i = 2'b00; bus.cmd_addr_i = '0; bus.cmd_wdata_i = '0;
    bus.pready_i = 1'b0; bus.prdata_i = '0; bus.pslverr_i = 1'b0;

    //            op        addr          wdata         rd0           rd1    w0   w1  e0 e1  rdata         err lat
    vecs[0] = mk(OP_READ,  32'hDEAD_CAFE, 32'h0,        32'h0000_1234, 32'h0, 0,   0,  0, 0, 32'h0000_1234, 0,  3);
    vecs[1] = mk(OP_WRITE, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0,        32'h0, 3,   0,  0, 0, 32'h0,         0,  6);
    vecs[2] = mk(OP_RMW,   32'hDEAD_CAFE, 32'h0,        32'hFFFF_FFFF, 32'h0, 0,   0,  0, 0, 32'hFFFF_FFFF, 0,  5);
    vecs[3] = mk(OP_RMW,   32'h0000_0020, 32'h0,        32'h0000_0055, 32'h0, 0,   0,  1, 0, 32'h0000_0055, 1,  3);
    vecs[4] = mk(OP_READ,  32'h0000_0030, 32'h0,        32'h1111_1111, 32'h0, 255, 0,  0, 0, 32'h0,         1,  18);
    vecs[5] = mk(OP_WRITE, 32'h0000_0040, 32'h1234_5678, 32'h0,        32'h0, 1,   0,  1, 0, 32'h0,         1,  4);
    vecs[6] = mk(OP_RMW,   32'h0000_0050, 32'h0,        32'h0000_0007, 32'h0, 2,   1,  0, 1, 32'h0000_0007, 1,  8);
    vecs[7] = mk(OP_RMW,   32'h0000_0060, 32'h0,        32'h0000_0009, 32'h0, 0,   255, 0, 0, 32'h0,        1,  20);
    vecs[8] = mk(OP_READ,  32'h0000_0070, 32'h0,        32'h0000_CAFE, 32'h0, 15,  0,  0, 0, 32'h0000_CAFE, 0,  18);

    // Reset state, sampled mid-cycle while reset is held.
    #12;
    chk("rst_psel", 64'(bus.psel_o), 64'd0);
    chk("rst_penable", 64'(bus.penable_o), 64'd0);
    chk("rst_paddr", 64'(bus.paddr_o), 64'd0);
    chk("rst_pwrite_pwdata", {31'd0, bus.pwrite_o, bus.pwdata_o}, 64'd0);
    chk("rst_rsp", {31'd0, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o}, 64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 64'(bus.cmd_ready_o), 64'd1);

    // NOP: accepted, no bus activity, no response.
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 2'(OP_NOP); bus.cmd_addr_i = 32'h99;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    seen = 0;
    repeat (4) begin
      if (bus.psel_o || bus.rsp_valid_o || !bus.cmd_ready_o) seen++;
      @(negedge clk);
    end
    chk("nop_quiet", 64'(seen), 64'd0);

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
      check_txn(vecs[i], $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_lat", i), 64'(o_lat), 64'(vecs[i].x_lat));
      chk($sformatf("vec%0d_tbl_rdata", i), 64'(o_rdata), 64'(vecs[i].x_rdata));
      chk($sformatf("vec%0d_tbl_err", i), 64'(o_err), 64'(vecs[i].x_err));
    end

    // Reset during the read ACCESS of an RMW: bus drops at once and no response follows.
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 2'(OP_RMW); bus.cmd_addr_i = 32'h0000_0100;
    bus.pready_i = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0; bus.cmd_op_i = 2'b00;
    n = 0;
    while (!(bus.psel_o && bus.penable_o) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_in_access", 64'(bus.psel_o && bus.penable_o), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_psel_penable", {62'd0, bus.psel_o, bus.penable_o}, 64'd0);
    chk("rstmid_paddr_pwrite", {31'd0, bus.pwrite_o, bus.paddr_o}, 64'd0);
    chk("rstmid_rsp_ready", {62'd0, bus.rsp_valid_o, bus.cmd_ready_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid_o || bus.psel_o) seen++;
    end
    chk("rstmid_no_rsp", 64'(seen), 64'd0);
    t = mk(OP_READ, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 32'h0, 1, 0, 0, 0, 32'h0BAD_F00D, 0, 4);
    run_txn(t, "post_rst_read");
    check_txn(t, "post_rst_read");

    for (int i = 0; i < 40; i++) begin
      t.op    = 2'($urandom_range(1, 3));
      t.addr  = $urandom();
      t.wdata = $urandom();
      t.rd0   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
      t.rd1   = $urandom();
      t.w0    = rand_wait();
      t.w1    = rand_wait();
      t.e0    = ($urandom_range(0, 7) == 0);
      t.e1    = ($urandom_range(0, 7) == 0);
      run_txn(t, $sformatf("rnd%0d", i));
      check_txn(t, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
